// File: rtl/lc3_pipe_ctrl_pkg.sv
// lc3_pkg: shared LC-3 decode definitions for the pipeline controller and the
// forwarding unit. It holds the opcode constants, the NOP encoding, the
// controller state enum, and the decode helper functions.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RES  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    localparam logic [15:0] NOP_IR = 16'h0000;

    typedef enum logic [1:0] {RUN, MEM1, MEM2, ERR} state_e;

    function automatic logic is_load(input logic [15:0] ir);
        return (ir != NOP_IR) &&
               (ir[15:12] == OP_LD || ir[15:12] == OP_LDR || ir[15:12] == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [15:0] ir);
        return (ir != NOP_IR) &&
               (ir[15:12] == OP_ST || ir[15:12] == OP_STR || ir[15:12] == OP_STI);
    endfunction

    function automatic logic is_indirect(input logic [15:0] ir);
        return (ir[15:12] == OP_LDI) || (ir[15:12] == OP_STI);
    endfunction

    function automatic logic is_memop(input logic [15:0] ir);
        return is_load(ir) || is_store(ir);
    endfunction

    // src1 is the base/first operand. For ST/STI it is the stored register.
    // JSR with ir[11]=0 is JSRR, which reads a base register.
    function automatic logic src1_valid(input logic [15:0] ir);
        unique case (ir[15:12])
            OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR,
            OP_JMP, OP_ST, OP_STI:          return 1'b1;
            OP_JSR:                         return ~ir[11];
            default:                        return 1'b0;
        endcase
    endfunction

    // src2 is the register operand of ADD/AND, or the stored register of STR.
    function automatic logic src2_valid(input logic [15:0] ir);
        return ((ir[15:12] == OP_ADD || ir[15:12] == OP_AND) && !ir[5]) ||
               (ir[15:12] == OP_STR);
    endfunction

endpackage

// File: rtl/lc3_pipe_ctrl_if.sv
// lc3_pipe_ctrl_if: the bundle of pipeline IRs and control signals exchanged
// between the datapath and the controller.
//   master: controller side. It reads the IRs, br_taken and mem_ack, and it
//           drives the stage enables, bubbles, the memory handshake, mem_err
//           and stall_cnt.
//   slave : datapath/memory side (the mirror image).
interface lc3_pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      ifid_ir;
    logic [15:0]      idex_ir;
    logic [15:0]      exmem_ir;
    logic             br_taken;
    logic             mem_ack;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_bubble;
    logic             exmem_we;
    logic             memwb_bubble;
    logic             mem_req;
    logic             mem_we;
    logic             mem_phase;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  ifid_ir, idex_ir, exmem_ir, br_taken, mem_ack,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we,
               memwb_bubble, mem_req, mem_we, mem_phase, mem_err, stall_cnt
    );

    modport slave (
        output ifid_ir, idex_ir, exmem_ir, br_taken, mem_ack,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we,
               memwb_bubble, mem_req, mem_we, mem_phase, mem_err, stall_cnt
    );
endinterface

// File: rtl/lc3_src_decode.sv
// lc3_src_decode: combinational source-register extraction for one IR. The
// forwarding unit also uses this module.
//   ir_i                   : instruction
//   src1_o/src1_valid_o    : first source register index and valid bit
//   src2_o/src2_valid_o    : second source register index and valid bit
module lc3_src_decode
    import lc3_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  src1_o,
    output logic        src1_valid_o,
    output logic [2:0]  src2_o,
    output logic        src2_valid_o
);
    // ST/STI read their data register from [11:9]. Everything else that has
    // a src1 reads it from [8:6].
    assign src1_o       = (ir_i[15:12] == OP_ST || ir_i[15:12] == OP_STI) ? ir_i[11:9] : ir_i[8:6];
    assign src1_valid_o = src1_valid(ir_i);
    assign src2_o       = (ir_i[15:12] == OP_STR) ? ir_i[11:9] : ir_i[2:0];
    assign src2_valid_o = src2_valid(ir_i);
endmodule

// File: rtl/lc3_pipe_ctrl.sv
// lc3_pipe_ctrl: stall/flush/freeze sequencing for the 5-stage LC-3 pipeline.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : lc3_pipe_ctrl_if.master. It carries the IRs of ID/EX/MEM,
//                br_taken and mem_ack in, and the stage enables, bubbles,
//                the memory handshake, mem_err and stall_cnt out.
// The memory handshake freeze outranks a redirect, and a redirect outranks a
// load-use stall.
module lc3_pipe_ctrl
    import lc3_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    lc3_pipe_ctrl_if.master bus
);
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [2:0] src1, src2;
    logic       src1_v, src2_v;
    logic       memop, store, indirect, load_use, freeze;
    logic       mem_req, mem_we, mem_phase, pc_we;

    lc3_src_decode u_src_decode (
        .ir_i         (bus.ifid_ir),
        .src1_o       (src1),
        .src1_valid_o (src1_v),
        .src2_o       (src2),
        .src2_valid_o (src2_v)
    );

    assign memop    = is_memop(bus.exmem_ir);
    assign store    = is_store(bus.exmem_ir);
    assign indirect = is_indirect(bus.exmem_ir);
    assign load_use = is_load(bus.idex_ir) &&
                      ((src1_v && src1 == bus.idex_ir[11:9]) ||
                       (src2_v && src2 == bus.idex_ir[11:9]));

    // NOTE: every signal is given a default at the top of this block, so
    // no path through the case statement can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_phase = 1'b0;
        freeze    = 1'b0;
        unique case (state_q)
            RUN: begin
                // The first access of LDI/STI is a pointer read, so it never
                // writes, even for STI.
                mem_req = memop;
                mem_we  = store && !indirect;
                if (memop && !bus.mem_ack) begin
                    state_d = MEM1;
                    freeze  = 1'b1;
                end else if (memop && indirect) begin
                    state_d = MEM2;
                    freeze  = 1'b1;
                end
            end
            MEM1: begin
                mem_req = 1'b1;
                mem_we  = store && !indirect;
                if (bus.mem_ack) begin
                    state_d = indirect ? MEM2 : RUN;
                    freeze  = indirect;
                end else begin
                    freeze  = 1'b1;
                    tmo_d   = tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST) state_d = ERR;
                end
            end
            MEM2: begin
                mem_req   = 1'b1;
                mem_phase = 1'b1;
                mem_we    = store;
                if (bus.mem_ack) begin
                    state_d = RUN;
                end else begin
                    freeze  = 1'b1;
                    tmo_d   = tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST) state_d = ERR;
                end
            end
            ERR: freeze = 1'b1;
            default: state_d = RUN;
        endcase
    end

    // A redirect discards the dependent instruction, so it cancels the stall.
    assign pc_we = !freeze && (bus.br_taken || !load_use);

    assign stall_cnt_d = (!pc_we && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            tmo_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_we        = pc_we;
    assign bus.ifid_we      = pc_we;
    assign bus.ifid_flush   = !freeze && bus.br_taken;
    assign bus.idex_we      = !freeze;
    assign bus.idex_bubble  = !freeze && (bus.br_taken || load_use);
    assign bus.exmem_we     = !freeze;
    assign bus.memwb_bubble = freeze;
    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_phase    = mem_phase;
    assign bus.mem_err      = (state_q == ERR);
    assign bus.stall_cnt    = stall_cnt_q;
endmodule
